// File: rtl/jk_pkg.sv
// jk_pkg: shared sequencer state, JK command encoding and the counter toggle-mask helper.
package jk_pkg;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  typedef enum logic [1:0] {JK_HOLD = 2'b00, JK_RST = 2'b01, JK_SET = 2'b10, JK_TGL = 2'b11} jk_cmd_t;
  function automatic logic [MAX_W-1:0] toggle_mask(input logic [MAX_W-1:0] q, input logic up);
    logic [MAX_W-1:0] m;
    m[0] = 1'b1;
    for (int i = 1; i < MAX_W; i++) m[i] = m[i-1] & (q[i-1] ~^ up);
    return m;
  endfunction
endpackage

// File: rtl/jk_bank.sv
// jk_bank: WIDTH negedge JK flip-flops with common async active-low clear.
module jk_bank #(parameter int WIDTH = 4) (
  input  logic             CLK,
  input  logic             not_RST,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] not_Q
);
  always_ff @(negedge CLK or negedge not_RST)
    if (!not_RST) Q <= '0;
    else Q <= (J & ~Q) | (~K & Q);
  assign not_Q = ~Q;
endmodule

// File: rtl/jk_counter_sequencer.sv
// jk_counter_sequencer: start-to-terminal up/down sequencer driving a JK bank through J/K excitation.
module jk_counter_sequencer import jk_pkg::*; #(parameter int WIDTH = 4) (
  input  logic             CLK,
  input  logic             not_RST,
  input  logic             start,
  input  logic             mode_up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] not_Q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done
);
  seq_state_t state;
  logic [WIDTH-1:0] mask;
  logic at_term, do_load, do_step;
  assign at_term = Q == terminal;
  assign mask    = WIDTH'(toggle_mask(MAX_W'(Q), mode_up));
  assign do_load = not_RST && state == IDLE && load;
  assign do_step = not_RST && state == RUN && !at_term;
  assign J = do_load ? load_val : do_step ? mask : '0;
  assign K = do_load ? ~load_val : do_step ? mask : '0;
  always_ff @(negedge CLK or negedge not_RST)
    if (!not_RST) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !load) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: if (at_term) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  jk_bank #(.WIDTH(WIDTH)) u_bank (.CLK(CLK), .not_RST(not_RST), .J(J), .K(K), .Q(Q), .not_Q(not_Q));
endmodule

// File: tb/tb_jk_counter_sequencer.sv
// tb_jk_counter_sequencer: directed and random checks against a behavioural counter model.
module tb_jk_counter_sequencer;
  logic CLK = 1'b0, not_RST = 1'b0, start = 1'b0, mode_up = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'h0, terminal = 4'h0;
  logic [3:0] Q, not_Q, J, K;
  logic busy, done;
  int checks = 0, errors = 0;
  int mq = 0;
  bit mb = 0, md = 0;

  jk_counter_sequencer #(.WIDTH(4)) dut (
    .CLK(CLK), .not_RST(not_RST), .start(start), .mode_up(mode_up), .load(load),
    .load_val(load_val), .terminal(terminal), .Q(Q), .not_Q(not_Q), .J(J), .K(K),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int stepped(input int q);
    return (q + (mode_up ? 1 : 15)) % 16;
  endfunction

  task automatic compare;
    int ej, ek;
    ej = 0;
    ek = 0;
    if (not_RST && !mb && !md && load) begin
      ej = int'(load_val);
      ek = ~int'(load_val) & 15;
    end else if (not_RST && mb && mq != int'(terminal)) begin
      ej = mq ^ stepped(mq);
      ek = ej;
    end
    chk("q", 32'(Q), mq);
    chk("not_q", 32'(not_Q), ~mq & 15);
    chk("busy", 32'(busy), 32'(mb));
    chk("done", 32'(done), 32'(md));
    chk("j", 32'(J), ej);
    chk("k", 32'(K), ek);
  endtask

  task automatic model_edge;
    if (mb) begin
      if (mq == int'(terminal)) begin
        mb = 0;
        md = 1;
      end else mq = stepped(mq);
    end else if (md) md = 0;
    else if (load) mq = int'(load_val);
    else if (start) mb = 1;
  endtask

  task automatic cyc(input logic s, input logic l, input logic [3:0] lv, input logic up, input logic [3:0] t);
    start = s;
    load = l;
    load_val = lv;
    mode_up = up;
    terminal = t;
    #1 compare();
    @(negedge CLK);
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_to_done(input logic up, input logic [3:0] t, input string name);
    int n = 0;
    while (!md && n < 40) begin
      cyc(1'b0, 1'b0, 4'h0, up, t);
      n++;
    end
    chk(name, 32'(done), 32'd1);
    cyc(1'b0, 1'b0, 4'h0, up, t);
  endtask

  task automatic async_reset;
    #1 not_RST = 1'b0;
    mq = 0;
    mb = 0;
    md = 0;
    #1 compare();
    not_RST = 1'b1;
  endtask

  initial begin
    load = 1'b1;
    load_val = 4'h9;
    #1 compare();
    chk("rst_j", 32'(J), 32'h0);
    @(posedge CLK);
    #1 not_RST = 1'b1;
    cyc(1'b0, 1'b1, 4'h9, 1'b0, 4'h0);
    chk("t1_q", 32'(Q), 32'h9);
    chk("t1_nq", 32'(not_Q), 32'h6);
    chk("t1_busy", 32'(busy), 32'h0);
    cyc(1'b0, 1'b1, 4'h0, 1'b1, 4'h5);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 4'h5);
    chk("t2_busy", 32'(busy), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 4'h5);
      chk("t2_seq", 32'(Q), 32'(i));
    end
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 4'h5);
    chk("t2_done", 32'(done), 32'h1);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 4'h5);
    chk("t2_idle", 32'({busy, done}), 32'h0);
    cyc(1'b0, 1'b1, 4'h2, 1'b0, 4'hE);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 4'hE);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 4'hE);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 4'hE);
    chk("t3_zero", 32'(Q), 32'h0);
    chk("t3_jk", 32'({J, K}), 32'hFF);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 4'hE);
    chk("t3_wrap", 32'(Q), 32'hF);
    run_to_done(1'b0, 4'hE, "t3_done");
    chk("t3_q", 32'(Q), 32'hE);
    cyc(1'b0, 1'b1, 4'h7, 1'b1, 4'h7);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 4'h7);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 4'h7);
    chk("t4_done", 32'({done, Q}), 32'h17);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 4'h7);
    cyc(1'b0, 1'b1, 4'h0, 1'b1, 4'h9);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 4'h9);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1, 4'h9);
    chk("t5_q3", 32'(Q), 32'h3);
    async_reset();
    chk("t5_abort", 32'({busy, Q}), 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1, 4'h9);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 4'h2);
    run_to_done(1'b1, 4'h2, "t5_done");
    cyc(1'b1, 1'b1, 4'hB, 1'b1, 4'hD);
    chk("t6_both", 32'({busy, Q}), 32'h0B);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 4'hD);
    cyc(1'b1, 1'b1, 4'h0, 1'b1, 4'hD);
    chk("t6_ign", 32'(Q), 32'hC);
    run_to_done(1'b1, 4'hD, "t6_done");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) async_reset();
      cyc(1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0), 4'($urandom),
          1'($urandom), ($urandom_range(7) == 0) ? 4'($urandom) : terminal);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
